// File: rtl/soc_bus_fabric_pkg.sv
// Shared types and constants for the single-master bus fabric.
// Holds FSM encodings, the error read-data pattern and clog2.
package soc_bus_fabric_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/soc_bus_fabric_decoder.sv
// Address to one-hot slave select with populated-slot check.
// Purely combinational.
module bus_decoder
  import soc_bus_fabric_pkg::*;
#(
  parameter int              NSLV      = 4,
  parameter int              AW        = 32,
  parameter int              SEL_LSB   = 12,
  parameter logic [NSLV-1:0] SLV_VALID = {NSLV{1'b1}},
  parameter int              SW        = clog2(NSLV)
) (
  input  logic [AW-1:0]   i_addr,
  output logic [SW-1:0]   o_sel,
  output logic [NSLV-1:0] o_onehot,
  output logic            o_valid
);

  logic w_unused_addr;

  assign w_unused_addr = ^i_addr;
  assign o_sel    = i_addr[SEL_LSB +: SW];
  assign o_valid  = SLV_VALID[o_sel];
  assign o_onehot = o_valid ? (NSLV'(1) << o_sel) : '0;

endmodule

// File: rtl/soc_bus_fabric.sv
// Single-master to NSLV-slave bus fabric with wait-state timeout
// and sticky error capture.
module soc_bus_fabric
  import soc_bus_fabric_pkg::*;
#(
  parameter int              NSLV      = 4,
  parameter int              DW        = 32,
  parameter int              AW        = 32,
  parameter int              SEL_LSB   = 12,
  parameter logic [NSLV-1:0] SLV_VALID = {NSLV{1'b1}},
  parameter int              TIMEOUT   = 15
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             m_en,
  input  logic             m_wen,
  input  logic [AW-1:0]    m_addr,
  input  logic [DW-1:0]    m_wdata,
  output logic [DW-1:0]    m_rdata,
  output logic             m_ready,
  output logic             m_err,
  output logic [NSLV-1:0]  s_en,
  output logic             s_wen,
  output logic [AW-1:0]    s_addr,
  output logic [DW-1:0]    s_wdata,
  input  logic [NSLV*DW-1:0] s_rdata,
  input  logic [NSLV-1:0]  s_ready,
  output logic             err_valid,
  output logic [AW-1:0]    err_addr,
  output logic [7:0]       err_cnt,
  input  logic             err_clr
);

  localparam int             SW        = clog2(NSLV);
  localparam logic [DW-1:0]  ERR_RDATA = DW'(ERR_DATA);
  localparam logic [7:0]     TO_LAST   = 8'(TIMEOUT - 1);

  state_e           r_state;
  state_e           w_next;
  logic [AW-1:0]    r_addr;
  logic [DW-1:0]    r_wdata;
  logic             r_wen;
  logic [SW-1:0]    r_sel;
  logic [7:0]       r_cnt;
  logic [DW-1:0]    r_m_rdata;
  logic             r_m_ready;
  logic             r_m_err;
  logic             r_err_valid;
  logic [AW-1:0]    r_err_addr;
  logic [7:0]       r_err_cnt;

  logic [AW-1:0]    w_dec_addr;
  logic [SW-1:0]    w_sel;
  logic [NSLV-1:0]  w_onehot;
  logic             w_valid;
  logic             w_rdy;
  logic             w_err;
  logic             w_tmo;
  logic             w_accept;
  logic [AW-1:0]    w_evt_addr;
  logic [DW-1:0]    w_rslice;

  // IDLE decodes the live request; ACCESS decodes the latched one
  assign w_dec_addr = (r_state == ST_IDLE) ? m_addr : r_addr;

  bus_decoder #(
    .NSLV      (NSLV),
    .AW        (AW),
    .SEL_LSB   (SEL_LSB),
    .SLV_VALID (SLV_VALID)
  ) u_dec (
    .i_addr   (w_dec_addr),
    .o_sel    (w_sel),
    .o_onehot (w_onehot),
    .o_valid  (w_valid)
  );

  assign w_rdy      = s_ready[r_sel];
  assign w_rslice   = s_rdata[r_sel*DW +: DW];
  assign w_accept   = (r_state == ST_IDLE) && m_en;
  assign w_evt_addr = (r_state == ST_IDLE) ? m_addr : r_addr;

  always_comb begin
    w_next = r_state;
    w_err  = 1'b0;
    w_tmo  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (m_en) begin
          w_next = w_valid ? ST_ACCESS : ST_RESP;
          w_err  = !w_valid;
        end
      end
      ST_ACCESS: begin
        if (w_rdy) begin
          w_next = ST_RESP;
        end else if (r_cnt == TO_LAST) begin
          w_next = ST_RESP;
          w_err  = 1'b1;
          w_tmo  = 1'b1;
        end
      end
      ST_RESP: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state   <= ST_IDLE;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wen     <= 1'b0;
      r_sel     <= '0;
      r_cnt     <= '0;
      r_m_rdata <= '0;
      r_m_ready <= 1'b0;
      r_m_err   <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_m_ready <= (w_next == ST_RESP);
      r_m_err   <= w_err;
      if (w_accept) begin
        r_addr  <= m_addr;
        r_wdata <= m_wdata;
        r_wen   <= m_wen;
        r_sel   <= w_sel;
      end
      if (r_state != ST_ACCESS)
        r_cnt <= '0;
      else if (!w_rdy)
        r_cnt <= r_cnt + 8'd1;
      if (w_tmo)
        r_m_rdata <= ERR_RDATA;
      else if (r_state == ST_ACCESS && w_rdy && !r_wen)
        r_m_rdata <= w_rslice;
    end
  end

  // A clear coinciding with a new error restarts the log at that error
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_err_valid <= 1'b0;
      r_err_addr  <= '0;
      r_err_cnt   <= '0;
    end else if (w_err) begin
      r_err_valid <= 1'b1;
      if (!r_err_valid || err_clr)
        r_err_addr <= w_evt_addr;
      if (err_clr)
        r_err_cnt <= 8'd1;
      else if (r_err_cnt != 8'hFF)
        r_err_cnt <= r_err_cnt + 8'd1;
    end else if (err_clr) begin
      r_err_valid <= 1'b0;
      r_err_cnt   <= '0;
    end
  end

  assign s_en      = (r_state == ST_ACCESS) ? w_onehot : '0;
  assign s_wen     = (r_state == ST_ACCESS) && r_wen;
  assign s_addr    = r_addr;
  assign s_wdata   = r_wdata;
  assign m_rdata   = r_m_rdata;
  assign m_ready   = r_m_ready;
  assign m_err     = r_m_err;
  assign err_valid = r_err_valid;
  assign err_addr  = r_err_addr;
  assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_soc_bus_fabric.sv
// Directed bench for soc_bus_fabric: latency, data, errors, reset.
// Slaves are modelled with a per-slave wait-state count.
module tb_soc_bus_fabric;

  logic          clk;
  logic          nreset;
  logic          m_en;
  logic          m_wen;
  logic [31:0]   m_addr;
  logic [31:0]   m_wdata;
  logic [31:0]   m_rdata;
  logic          m_ready;
  logic          m_err;
  logic [3:0]    s_en;
  logic          s_wen;
  logic [31:0]   s_addr;
  logic [31:0]   s_wdata;
  logic [127:0]  s_rdata;
  logic [3:0]    s_ready;
  logic          err_valid;
  logic [31:0]   err_addr;
  logic [7:0]    err_cnt;
  logic          err_clr;

  int errors = 0;
  int checks = 0;

  int       wait_cfg [4];
  int       acc_cnt  [4];
  logic [3:0] noise;

  int          t_lat;
  logic [31:0] t_rdata;
  logic        t_err;
  int          t_encnt;
  logic [3:0]  t_enseen;
  logic        t_wok;

  soc_bus_fabric #(
    .NSLV      (4),
    .DW        (32),
    .AW        (32),
    .SEL_LSB   (12),
    .SLV_VALID (4'b0111),
    .TIMEOUT   (15)
  ) dut (
    .clk       (clk),
    .nreset    (nreset),
    .m_en      (m_en),
    .m_wen     (m_wen),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_rdata   (m_rdata),
    .m_ready   (m_ready),
    .m_err     (m_err),
    .s_en      (s_en),
    .s_wen     (s_wen),
    .s_addr    (s_addr),
    .s_wdata   (s_wdata),
    .s_rdata   (s_rdata),
    .s_ready   (s_ready),
    .err_valid (err_valid),
    .err_addr  (err_addr),
    .err_cnt   (err_cnt),
    .err_clr   (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign s_rdata = {32'h3333_3333, 32'h2222_2222,
                    32'h1111_1111, 32'h1234_5678};

  always @(posedge clk or negedge nreset) begin
    for (int i = 0; i < 4; i++) begin
      if (!nreset) acc_cnt[i] <= 0;
      else acc_cnt[i] <= s_en[i] ? acc_cnt[i] + 1 : 0;
    end
  end

  always_comb begin
    s_ready = '0;
    for (int i = 0; i < 4; i++)
      s_ready[i] = (s_en[i] && acc_cnt[i] >= wait_cfg[i]) || noise[i];
  end

  task automatic do_txn(input logic wen, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic clr);
    @(posedge clk); #1;
    m_en = 1'b1; m_wen = wen; m_addr = addr; m_wdata = wdata;
    err_clr = clr;
    t_lat = 0; t_encnt = 0; t_enseen = '0; t_wok = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      t_lat = n;
      if (s_en != 4'b0) begin
        t_encnt++;
        t_enseen |= s_en;
        if (s_wdata !== wdata || s_addr !== addr || s_wen !== wen)
          t_wok = 1'b0;
      end
      if (m_ready === 1'b1) break;
    end
    t_rdata = m_rdata;
    t_err   = m_err;
    checks++;
    if (m_ready !== 1'b1) begin
      errors++;
      $display("FAIL txn_timeout: m_ready=%b required 1", m_ready);
    end
    @(posedge clk); #1;
    m_en = 1'b0;
  endtask

  task automatic test_reset;
    nreset = 1'b0;
    #12;
    checks++;
    if ({s_en, s_wen, s_addr, s_wdata, m_rdata, m_ready, m_err}
        !== '0) begin
      errors++;
      $display("FAIL reset_bus: s_en=%h m_rdata=%h m_ready=%b m_err=%b required 0",
               s_en, m_rdata, m_ready, m_err);
    end
    checks++;
    if ({err_valid, err_addr, err_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_err: valid=%b addr=%h cnt=%0d required 0",
               err_valid, err_addr, err_cnt);
    end
    @(negedge clk);
    nreset = 1'b1;
  endtask

  task automatic test_read_zero_wait;
    wait_cfg[0] = 0;
    do_txn(1'b0, 32'h0000_0010, 32'h0, 1'b0);
    checks++;
    if (t_lat !== 2) begin
      errors++;
      $display("FAIL rd_latency: got %0d required 2", t_lat);
    end
    checks++;
    if (t_rdata !== 32'h1234_5678 || t_err !== 1'b0) begin
      errors++;
      $display("FAIL rd_data: got %h err=%b required 12345678 err=0",
               t_rdata, t_err);
    end
    checks++;
    if (t_enseen !== 4'b0001 || t_encnt !== 1 || !t_wok) begin
      errors++;
      $display("FAIL rd_sen: s_en=%b cycles=%0d ok=%b required 0001 1 1",
               t_enseen, t_encnt, t_wok);
    end
    @(negedge clk);
    checks++;
    if (m_ready !== 1'b0 || m_rdata !== 32'h1234_5678) begin
      errors++;
      $display("FAIL rd_hold: m_ready=%b m_rdata=%h required 0 12345678",
               m_ready, m_rdata);
    end
  endtask

  task automatic test_write_wait;
    wait_cfg[1] = 3;
    noise = 4'b1001;
    do_txn(1'b1, 32'h0000_1004, 32'hCAFE_0001, 1'b0);
    noise = 4'b0000;
    checks++;
    if (t_enseen !== 4'b0010 || t_encnt !== 4) begin
      errors++;
      $display("FAIL wr_sen: s_en=%b cycles=%0d required 0010 4",
               t_enseen, t_encnt);
    end
    checks++;
    if (!t_wok) begin
      errors++;
      $display("FAIL wr_bus: s_wdata/s_addr/s_wen ok=%b required 1", t_wok);
    end
    checks++;
    if (t_lat !== 5 || t_err !== 1'b0) begin
      errors++;
      $display("FAIL wr_latency: got %0d err=%b required 5 err=0",
               t_lat, t_err);
    end
    checks++;
    if (t_rdata !== 32'h1234_5678) begin
      errors++;
      $display("FAIL wr_rdata_hold: got %h required 12345678", t_rdata);
    end
  endtask

  task automatic test_invalid_slave(input logic [31:0] addr,
                                    input logic [31:0] exp_addr,
                                    input logic [7:0] exp_cnt);
    do_txn(1'b0, addr, 32'h0, 1'b0);
    checks++;
    if (t_lat !== 1 || t_err !== 1'b1 || t_enseen !== 4'b0) begin
      errors++;
      $display("FAIL inv_resp: lat=%0d err=%b s_en=%b required 1 1 0000",
               t_lat, t_err, t_enseen);
    end
    checks++;
    if (err_valid !== 1'b1 || err_addr !== exp_addr || err_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL inv_log: valid=%b addr=%h cnt=%0d required 1 %h %0d",
               err_valid, err_addr, err_cnt, exp_addr, exp_cnt);
    end
  endtask

  task automatic test_timeout;
    @(posedge clk); #1;
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    checks++;
    if (err_valid !== 1'b0 || err_cnt !== 8'd0) begin
      errors++;
      $display("FAIL err_clr: valid=%b cnt=%0d required 0 0",
               err_valid, err_cnt);
    end
    wait_cfg[2] = 255;
    noise = 4'b1011;
    do_txn(1'b0, 32'h0000_2008, 32'h0, 1'b0);
    checks++;
    if (t_lat !== 16 || t_err !== 1'b1 || t_rdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL tmo_resp: lat=%0d err=%b rdata=%h required 16 1 deadbeef",
               t_lat, t_err, t_rdata);
    end
    checks++;
    if (err_valid !== 1'b1 || err_addr !== 32'h2008 || err_cnt !== 8'd1) begin
      errors++;
      $display("FAIL tmo_log1: valid=%b addr=%h cnt=%0d required 1 2008 1",
               err_valid, err_addr, err_cnt);
    end
    do_txn(1'b1, 32'h0000_200C, 32'h55AA_55AA, 1'b0);
    noise = 4'b0000;
    checks++;
    if (err_cnt !== 8'd2 || err_addr !== 32'h2008 || t_lat !== 16) begin
      errors++;
      $display("FAIL tmo_log2: cnt=%0d addr=%h lat=%0d required 2 2008 16",
               err_cnt, err_addr, t_lat);
    end
  endtask

  task automatic test_reset_mid;
    @(posedge clk); #1;
    m_en = 1'b1; m_wen = 1'b0; m_addr = 32'h0000_2000;
    repeat (3) @(posedge clk);
    #3;
    nreset = 1'b0;
    #1;
    checks++;
    if ({s_en, s_wen, s_addr, s_wdata, m_rdata, m_ready, m_err,
         err_valid, err_addr, err_cnt} !== '0) begin
      errors++;
      $display("FAIL rst_mid: s_en=%b m_rdata=%h err_valid=%b err_cnt=%0d required 0",
               s_en, m_rdata, err_valid, err_cnt);
    end
    m_en = 1'b0;
    @(negedge clk);
    nreset = 1'b1;
    do_txn(1'b0, 32'h0000_0020, 32'h0, 1'b0);
    checks++;
    if (t_lat !== 2 || t_rdata !== 32'h1234_5678 || t_err !== 1'b0) begin
      errors++;
      $display("FAIL rst_recover: lat=%0d rdata=%h err=%b required 2 12345678 0",
               t_lat, t_rdata, t_err);
    end
  endtask

  task automatic test_clr_same_cycle;
    do_txn(1'b0, 32'h0000_3FF0, 32'h0, 1'b1);
    checks++;
    if (err_valid !== 1'b1 || err_cnt !== 8'd1 || err_addr !== 32'h3FF0) begin
      errors++;
      $display("FAIL clr_same: valid=%b cnt=%0d addr=%h required 1 1 3ff0",
               err_valid, err_cnt, err_addr);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] mask;
    mask = '0;
    wait_cfg[0] = 0;
    @(posedge clk); #1;
    m_en = 1'b1; m_wen = 1'b0; m_addr = 32'h0000_0040;
    @(posedge clk);
    for (int n = 1; n <= 7; n++) begin
      @(negedge clk);
      mask[n] = m_ready;
    end
    #1;
    m_en = 1'b0;
    repeat (4) @(posedge clk);
    checks++;
    if (mask !== 8'b0010_0100) begin
      errors++;
      $display("FAIL back_to_back: m_ready cycles=%b required 00100100", mask);
    end
  endtask

  initial begin
    nreset = 1'b0; m_en = 1'b0; m_wen = 1'b0;
    m_addr = '0; m_wdata = '0; err_clr = 1'b0; noise = '0;
    for (int i = 0; i < 4; i++) wait_cfg[i] = 0;
    test_reset();
    test_read_zero_wait();
    test_write_wait();
    test_invalid_slave(32'h0000_3000, 32'h0000_3000, 8'd1);
    test_timeout();
    test_reset_mid();
    test_invalid_slave(32'h0000_3000, 32'h0000_3000, 8'd1);
    test_invalid_slave(32'h0000_3100, 32'h0000_3000, 8'd2);
    test_clr_same_cycle();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/soc_bus_fabric.md
SOC_BUS_FABRIC -- requirements
Module: soc_bus_fabric

Interface
REQ-001 Parameter NSLV, default 4: number of slave ports, power of two, 2..16.
REQ-002 Parameter DW, default 32: data width.
REQ-003 Parameter AW, default 32: address width.
REQ-004 Parameter SEL_LSB, default 12: lowest address bit of the slave-select field, which is log2(NSLV) bits wide.
REQ-005 Parameter SLV_VALID, default {NSLV{1'b1}}: bit i set means slave i is populated.
REQ-006 Parameter TIMEOUT, default 15: maximum ACCESS cycles to wait for s_ready, range 1..255.
REQ-007 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-008 Port nreset, input, 1: asynchronous, active-low reset.
REQ-009 Ports m_en and m_wen, inputs, 1 each: master request; m_wen=1 means write.
REQ-010 Ports m_addr (AW) and m_wdata (DW), inputs: master address and write data.
REQ-011 Port m_rdata, output, DW: read data returned to the master.
REQ-012 Ports m_ready and m_err, outputs, 1 each: completion pulse and error flag for the completed transaction.
REQ-013 Port s_en, output, NSLV: one-hot slave enable.
REQ-014 Ports s_wen (1), s_addr (AW) and s_wdata (DW), outputs: shared by all slaves.
REQ-015 Port s_rdata, input, NSLV*DW: flattened slave read data; slave i occupies bits [i*DW +: DW].
REQ-016 Port s_ready, input, NSLV: per-slave completion.
REQ-017 Ports err_valid (1), err_addr (AW) and err_cnt (8), outputs: error status.
REQ-018 Port err_clr, input, 1: clears err_valid and err_cnt.

Function
REQ-019 The block SHALL implement an FSM with three states: IDLE, ACCESS and RESP.
REQ-020 In IDLE, a sampled m_en SHALL latch m_addr, m_wdata and m_wen into internal registers, and the slave index SHALL be decoded as sel = m_addr[SEL_LSB +: log2 NSLV].
REQ-021 If SLV_VALID[sel]=0, the FSM SHALL go IDLE->RESP with the error flag set, and no s_en SHALL be asserted.
REQ-022 Otherwise, the FSM SHALL go IDLE->ACCESS; while in ACCESS, s_en[sel]=1 and s_addr, s_wdata and s_wen SHALL be driven from the latched registers.
REQ-023 The wait counter SHALL clear on ACCESS entry and increment on each ACCESS cycle in which s_ready[sel]=0.
REQ-024 When s_ready[sel]=1 in ACCESS, the FSM SHALL go to RESP; on a read, m_rdata SHALL capture s_rdata slice sel; on a write, m_rdata SHALL be held unchanged.
REQ-025 When the counter reaches TIMEOUT with no ready, the FSM SHALL go to RESP with the error flag set, and m_rdata SHALL be 32'hDEAD_BEEF truncated or zero-extended to DW.
REQ-026 s_ready bits of unselected slaves SHALL be ignored.
REQ-027 In RESP, m_ready=1 for exactly one cycle, m_err shall equal the error flag, and the next state SHALL be IDLE; m_en SHALL not be sampled in RESP.
REQ-028 Latency: for a slave with zero wait states, m_ready SHALL assert 2 cycles after the edge that samples m_en; each slave wait cycle adds 1 cycle.
REQ-029 The master SHALL hold m_en until m_ready; if m_en is still high in the IDLE cycle after RESP, that SHALL start a new transaction.
REQ-030 On the first error while err_valid=0, the block SHALL set err_valid and load err_addr with the latched address.
REQ-031 A later error SHALL leave err_addr unchanged and SHALL increment err_cnt, saturating at 255.
REQ-032 err_clr SHALL clear err_valid and err_cnt; if err_clr and a new error occur in the same cycle, the new error SHALL be recorded (err_valid=1, err_cnt=1, err_addr updated).
REQ-033 m_rdata SHALL hold its value between transactions.

Reset
REQ-034 While nreset=0, regardless of any in-flight transaction: FSM=IDLE, counter=0, s_en=0, s_wen=0, s_addr=0, s_wdata=0, m_rdata=0, m_ready=0, m_err=0, err_valid=0, err_addr=0, err_cnt=0.
REQ-035 The first m_en SHALL be sampled on the first rising clk edge after nreset deasserts.

Structure
REQ-036 A shared package SHALL hold the FSM state encodings, the 32'hDEAD_BEEF error-data constant and a clog2 function.
REQ-037 A single sub-module, bus_decoder, SHALL be used: a combinational address-to-one-hot and valid decode parameterised by NSLV, SEL_LSB and SLV_VALID.

Verification
REQ-038 Read, addr 0x0000_0010, slave 0 ready in the same cycle with rdata 0x1234_5678 -> m_ready 2 cycles after the sampling edge, m_rdata=0x1234_5678, m_err=0.
REQ-039 Write, addr 0x0000_1004, slave 1 with 3 wait cycles -> s_en=4'b0010 for 4 cycles, s_wdata matches m_wdata, m_ready at cycle 5, m_err=0.
REQ-040 SLV_VALID=4'b0111, read addr 0x0000_3000 -> s_en never asserted, m_ready at cycle 1, m_err=1, err_valid=1, err_addr=0x0000_3000, err_cnt=1.
REQ-041 TIMEOUT=15, slave 2 never ready -> m_ready at cycle 16, m_err=1, m_rdata=0xDEAD_BEEF; a second timeout gives err_cnt=2 with err_addr unchanged.
REQ-042 nreset pulsed low in the middle of ACCESS -> all outputs 0 immediately; a following read of slave 0 completes normally.
REQ-043 err_clr asserted in the same cycle as a new error completes -> err_valid=1, err_cnt=1, err_addr equal to the new address.
